// File: rtl/mem_wr_buf_if.sv
// Bus bundle for the memory write buffer: request handshake, memory write port,
// forwarding lookup and occupancy status.
interface mem_wr_buf_if #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // A request transfers on a rising edge where in_valid && in_ready; in_ready
    // depends only on registered occupancy and rst, never on in_valid.
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW-1:0] l_addr;
    logic          l_hit;
    logic [DW-1:0] l_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output in_valid, in_addr, in_data, drain_en, l_addr,
        input  in_ready, w_en, w_addr, w_data, l_hit, l_data, count, empty, full
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, l_addr,
        output in_ready, w_en, w_addr, w_data, l_hit, l_data, count, empty, full
    );
endinterface

// File: rtl/mem_wr_buf.sv
// In-order write buffer in front of a small register-file memory, retiring one
// entry per cycle and forwarding the youngest pending write on lookup.
module mem_wr_buf #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    mem_wr_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_idx;
    logic          w_hit;
    logic [DW-1:0] w_hit_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full && !rst;
    assign w_pop   = !w_empty && bus.drain_en && !rst;

    // When empty, the slot just behind rd_ptr still holds the last retired entry
    // (all zero straight after reset), so the write port keeps showing it.
    assign w_head = w_empty ? (r_rd_ptr - PW'(1)) : r_rd_ptr;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == bus.l_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr]  <= bus.in_addr;
                r_data[r_wr_ptr]  <= bus.in_data;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready = !w_full && !rst;
    assign bus.w_en     = w_pop;
    assign bus.w_addr   = r_addr[w_head];
    assign bus.w_data   = r_data[w_head];
    assign bus.l_hit    = w_hit && !rst;
    assign bus.l_data   = rst ? '0 : w_hit_data;
    assign bus.count    = r_count;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
endmodule

// File: tb/tb_mem_wr_buf.sv
// Randomized bench for mem_wr_buf: a queue-based model of buffer contents
// predicts status and lookup, and a monitor checks retired writes in order.
module tb_mem_wr_buf;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int W     = AW + DW;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_pop;

    mem_wr_buf_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

    mem_wr_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive on the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge should produce.
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic de, input logic r, input logic [AW-1:0] la);
        logic          exp_ready;
        logic          exp_wen;
        logic          exp_hit;
        logic [DW-1:0] exp_ld;
        logic [W-1:0]  head;
        logic [CW-1:0] exp_cnt;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.drain_en = de;
        bus.l_addr   = la;
        #1;
        exp_cnt   = CW'(model_q.size());
        exp_ready = (model_q.size() < DEPTH) && !r;
        exp_wen   = (model_q.size() > 0) && de && !r;
        exp_hit   = 1'b0;
        exp_ld    = '0;
        if (!r) begin
            foreach (model_q[k]) begin
                if (model_q[k][W-1:DW] == la) begin
                    exp_hit = 1'b1;
                    exp_ld  = model_q[k][DW-1:0];
                end
            end
        end
        head = (model_q.size() > 0) ? model_q[0] : last_pop;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("count",    32'(bus.count),    32'(exp_cnt));
        check("empty",    32'(bus.empty),    32'(model_q.size() == 0));
        check("full",     32'(bus.full),     32'(model_q.size() == DEPTH));
        check("w_en",     32'(bus.w_en),     32'(exp_wen));
        check("w_addr",   32'(bus.w_addr),   32'(head[W-1:DW]));
        check("w_data",   32'(bus.w_data),   32'(head[DW-1:0]));
        check("l_hit",    32'(bus.l_hit),    32'(exp_hit));
        check("l_data",   32'(bus.l_data),   32'(exp_ld));
        if (r) begin
            model_q.delete();
            exp_q.delete();
            last_pop = '0;
        end else begin
            if (exp_wen) last_pop = model_q.pop_front();
            if (v && exp_ready) begin
                model_q.push_back({a, d});
                exp_q.push_back({a, d});
            end
        end
    endtask

    // Monitor: every memory write must be the oldest outstanding accepted request.
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        forever begin
            @(negedge clk);
            #2;
            if (bus.w_en === 1'b1) begin
                got = {bus.w_addr, bus.w_data};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got %0h expected none at %0t", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL write_order: got %0h expected %0h at %0t", got, want, $time);
                    end
                end
            end
        end
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        last_pop     = '0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.drain_en = 1'b0;
        bus.l_addr   = '0;
        repeat (2) @(negedge clk);
        cycle(0, 0, 0, 0, 1, 0);

        // reset then single write
        cycle(1, 3, 16'hBEEF, 1, 0, 3);
        cycle(0, 0, 16'h0000, 1, 0, 3);
        cycle(0, 0, 16'h0000, 1, 0, 3);

        // fill and backpressure, then in-order drain
        for (int i = 0; i < 5; i++) cycle(1, AW'(i), DW'(16'h0100 + i), 0, 0, AW'(i));
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0, AW'(i));

        // wrap-around with simultaneous push and pop
        cycle(1, 1, 16'h0001, 0, 0, 0);
        for (int i = 2; i <= 10; i++) cycle(1, AW'(i), DW'(i), 1, 0, AW'(i - 1));
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);

        // forwarding of the youngest duplicate
        cycle(1, 5, 16'h1111, 0, 0, 5);
        cycle(1, 5, 16'h2222, 0, 0, 5);
        cycle(0, 0, 0, 0, 0, 5);
        cycle(0, 0, 0, 0, 0, 6);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 5);

        // lookup during the pop cycle
        cycle(1, 2, 16'hAAAA, 1, 0, 2);
        cycle(0, 0, 0, 1, 0, 2);
        cycle(0, 0, 0, 1, 0, 2);

        // reset with entries queued discards them
        for (int i = 0; i < 3; i++) cycle(1, AW'(i + 4), DW'(16'h3000 + i), 0, 0, 4);
        cycle(0, 0, 0, 0, 1, 4);
        cycle(0, 0, 0, 1, 0, 4);
        cycle(1, 7, 16'h7777, 1, 0, 7);
        cycle(0, 0, 0, 1, 0, 7);

        // random traffic with phases of varying drain pressure
        for (int i = 0; i < 600; i++) begin
            int drain_pct;
            drain_pct = ((i / 50) % 3 == 0) ? 20 : (((i / 50) % 3 == 1) ? 50 : 90);
            cycle($urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 7)),
                  DW'($urandom),
                  $urandom_range(0, 99) < drain_pct,
                  $urandom_range(0, 79) == 0,
                  AW'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #3;
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
